// File: rtl/coin_acceptor_if.sv
// Purpose: groups the coin, user and wash-controller signals of the coin acceptor.
// Latency: none; this file holds wiring only.
// Backpressure: none; the only flow control is wash_done from the controller.
//
// Signals (direction as seen by the acceptor, modport slave):
//   inputs : coin_valid, coin_type[1:0], cancel, double_wash_req, wash_done
//   outputs: coin_in, double_wash, credit[7:0], coin_reject, refund_valid,
//            refund_amount[7:0], busy
// The master modport is the mirror image, for the side that drives coins and
// watches the results.
interface coin_acceptor_if;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       cancel;
    logic       double_wash_req;
    logic       wash_done;
    logic       coin_in;
    logic       double_wash;
    logic [7:0] credit;
    logic       coin_reject;
    logic       refund_valid;
    logic [7:0] refund_amount;
    logic       busy;

    modport slave (
        input  coin_valid,
        input  coin_type,
        input  cancel,
        input  double_wash_req,
        input  wash_done,
        output coin_in,
        output double_wash,
        output credit,
        output coin_reject,
        output refund_valid,
        output refund_amount,
        output busy
    );

    modport master (
        output coin_valid,
        output coin_type,
        output cancel,
        output double_wash_req,
        output wash_done,
        input  coin_in,
        input  double_wash,
        input  credit,
        input  coin_reject,
        input  refund_valid,
        input  refund_amount,
        input  busy
    );
endinterface

// File: rtl/coin_acceptor.sv
// Purpose: collects coins toward a single/double wash price, starts the wash controller, pays change/refunds.
// Latency: coin strobe -> credit 1 cycle; price-completing coin -> coin_in 2 cycles (wash_done=1).
// Backpressure: waits in COLLECT while wash_done=0; coins outside COLLECT/IDLE or over CREDIT_MAX are rejected.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset; clears state, credit and every output
//   bus    - coin_acceptor_if.slave: coin/cancel/program inputs, wash_done from the
//            controller; coin_in/double_wash to the controller; credit, coin_reject,
//            refund_valid/refund_amount and busy to the user side
//
// Every output comes straight from a flop. The effects of the START state
// (coin_in, program select, change payout, credit clear) are loaded on the edge
// that enters START, so they are all visible together during the single START cycle.
module coin_acceptor #(
    parameter logic [7:0] PRICE_SINGLE = 8'd10,
    parameter logic [7:0] PRICE_DOUBLE = 8'd15,
    parameter logic [7:0] CREDIT_MAX   = 8'd50
) (
    input  logic            clk,
    input  logic            rst_n,
    coin_acceptor_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        START   = 2'd2,
        RUNNING = 2'd3
    } state_t;

    state_t     state_q;
    logic [7:0] credit_q;
    logic       seen_low_q;
    logic       coin_in_q;
    logic       double_wash_q;
    logic       coin_reject_q;
    logic       refund_valid_q;
    logic [7:0] refund_amount_q;
    logic       busy_q;

    // Face value of the presented coin.
    logic [7:0] coin_value;
    always_comb begin
        coin_value = 8'd0;
        case (bus.coin_type)
            2'b00:   coin_value = 8'd1;
            2'b01:   coin_value = 8'd2;
            2'b10:   coin_value = 8'd5;
            default: coin_value = 8'd10;
        endcase
    end

    // Nine-bit sum so a large credit plus a coin can never wrap past the limit.
    logic [8:0] credit_sum;
    logic       coin_fits;
    assign credit_sum = {1'b0, credit_q} + {1'b0, coin_value};
    assign coin_fits  = (credit_sum <= {1'b0, CREDIT_MAX});

    // Price follows the program select live while collecting, so the user may
    // change their mind up to the cycle the wash starts.
    logic [7:0] price;
    logic       can_start;
    logic [7:0] change;
    assign price     = bus.double_wash_req ? PRICE_DOUBLE : PRICE_SINGLE;
    assign can_start = (credit_q >= price) && bus.wash_done;
    assign change    = credit_q - price;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            credit_q        <= 8'd0;
            seen_low_q      <= 1'b0;
            coin_in_q       <= 1'b0;
            double_wash_q   <= 1'b0;
            coin_reject_q   <= 1'b0;
            refund_valid_q  <= 1'b0;
            refund_amount_q <= 8'd0;
            busy_q          <= 1'b0;
        end else begin
            // Pulse outputs last exactly one cycle unless re-armed below.
            coin_in_q       <= 1'b0;
            coin_reject_q   <= 1'b0;
            refund_valid_q  <= 1'b0;
            refund_amount_q <= 8'd0;

            case (state_q)
                IDLE: begin
                    // Cancel with nothing inserted has nothing to refund.
                    if (bus.coin_valid) begin
                        credit_q <= coin_value;
                        state_q  <= COLLECT;
                        busy_q   <= 1'b1;
                    end
                end

                COLLECT: begin
                    if (bus.cancel) begin
                        refund_valid_q  <= 1'b1;
                        refund_amount_q <= credit_q;
                        credit_q        <= 8'd0;
                        // A coin arriving with the cancel is handed straight back.
                        coin_reject_q   <= bus.coin_valid;
                        state_q         <= IDLE;
                        busy_q          <= 1'b0;
                    end else if (bus.coin_valid) begin
                        // The start check waits for a cycle without a coin, so the
                        // price comparison always sees the settled credit.
                        if (coin_fits) begin
                            credit_q <= credit_sum[7:0];
                        end else begin
                            coin_reject_q <= 1'b1;
                        end
                    end else if (can_start) begin
                        coin_in_q       <= 1'b1;
                        double_wash_q   <= bus.double_wash_req;
                        refund_valid_q  <= (change != 8'd0);
                        refund_amount_q <= change;
                        credit_q        <= 8'd0;
                        state_q         <= START;
                    end
                end

                START: begin
                    coin_reject_q <= bus.coin_valid;
                    seen_low_q    <= 1'b0;
                    state_q       <= RUNNING;
                end

                RUNNING: begin
                    coin_reject_q <= bus.coin_valid;
                    // The controller must be seen busy before its idle level
                    // counts as the end of this wash; otherwise a slow controller
                    // that has not dropped wash_done yet would end us at once.
                    if (bus.wash_done && seen_low_q) begin
                        double_wash_q <= 1'b0;
                        seen_low_q    <= 1'b0;
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                    end else if (!bus.wash_done) begin
                        seen_low_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.coin_in       = coin_in_q;
    assign bus.double_wash   = double_wash_q;
    assign bus.credit        = credit_q;
    assign bus.coin_reject   = coin_reject_q;
    assign bus.refund_valid  = refund_valid_q;
    assign bus.refund_amount = refund_amount_q;
    assign bus.busy          = busy_q;

    // START lasts one cycle, so the start pulse can never be stretched.
    a_coin_in_single: assert property (@(posedge clk) disable iff (!rst_n)
        coin_in_q |=> !coin_in_q);

    // The refund amount reads zero whenever no refund is being paid.
    a_refund_amount_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !refund_valid_q |-> (refund_amount_q == 8'd0));

    // Credit never exceeds the holding limit.
    a_credit_limit: assert property (@(posedge clk) disable iff (!rst_n)
        credit_q <= CREDIT_MAX);

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter PRICE_SINGLE, default 8'd10, credit units charged for a single wash.
REQ-002 Parameter PRICE_DOUBLE, default 8'd15, credit units charged for a double wash.
REQ-003 Parameter CREDIT_MAX, default 8'd50, maximum credit that may be held.
REQ-004 clk  input  1  system clock; all logic rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 coin_valid  input  1  one-cycle strobe, a coin is presented.
REQ-007 coin_type  input  2  coin value: 00=1, 01=2, 10=5, 11=10 units; valid only with coin_valid.
REQ-008 cancel  input  1  user cancel request, level, sampled each cycle.
REQ-009 double_wash_req  input  1  user program select, 1 = double wash.
REQ-010 wash_done  input  1  status from wash controller, 1 = controller idle.
REQ-011 coin_in  output  1  start pulse to wash controller.
REQ-012 double_wash  output  1  program select to wash controller, held for the whole cycle.
REQ-013 credit  output  8  current accumulated credit.
REQ-014 coin_reject  output  1  one-cycle pulse, presented coin returned unaccepted.
REQ-015 refund_valid  output  1  one-cycle pulse, refund_amount is to be paid out.
REQ-016 refund_amount  output  8  amount to pay out, valid with refund_valid, 0 otherwise.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, COLLECT, START, RUNNING; all outputs registered.
REQ-019 Price = PRICE_DOUBLE when double_wash_req=1, else PRICE_SINGLE, evaluated every cycle in COLLECT.
REQ-020 IDLE: coin_valid -> credit <= coin value, go COLLECT next cycle; cancel alone ignored.
REQ-021 COLLECT priority: cancel > coin_valid > start check.
REQ-022 COLLECT, cancel=1: refund_valid=1, refund_amount=credit, credit<=0, go IDLE; a coin in the same cycle gets coin_reject=1.
REQ-023 COLLECT, coin_valid, credit+value <= CREDIT_MAX: credit += value; start check deferred to next cycle.
REQ-024 COLLECT, coin_valid, credit+value > CREDIT_MAX: coin_reject=1, credit unchanged; 9-bit sum used, no wrap.
REQ-025 COLLECT, no cancel, no coin, credit >= price, wash_done=1: go START; with wash_done=0, stay COLLECT.
REQ-026 START (exactly one cycle): coin_in=1; double_wash <= double_wash_req; refund_valid=1 with refund_amount=credit-price if nonzero; credit<=0; go RUNNING.
REQ-027 RUNNING: sticky flag seen_low set when wash_done=0; go IDLE on wash_done=1 with seen_low set; clear double_wash and seen_low on exit.
REQ-028 Any coin_valid in START or RUNNING -> coin_reject=1; cancel ignored in START and RUNNING.
REQ-029 coin_in, coin_reject, refund_valid are never high for two consecutive cycles from one event.
REQ-030 Latency: coin completing price -> coin_in high 2 cycles after that coin's strobe cycle (with wash_done=1).

Reset
REQ-031 rst_n low: state IDLE, credit=0, seen_low=0, all outputs 0, immediately and asynchronously.
REQ-032 Reset mid-COLLECT or mid-RUNNING discards credit with no refund pulse; double_wash drops to 0.
REQ-033 Reset release: first coin accepted on the first rising edge with rst_n high.

Verification
REQ-034 Single wash: coins 5,5 (PRICE_SINGLE=10), wash_done=1 -> coin_in pulse 2 cycles after second coin, double_wash=0, no refund.
REQ-035 Double wash with change: double_wash_req=1, coins 10,10 -> coin_in pulse, double_wash=1, refund_valid with refund_amount=5; double_wash stays 1 until wash_done 1->0->1, then 0.
REQ-036 Overflow: credit 45, coin 10 -> coin_reject=1, credit stays 45; coin 5 -> credit 50.
REQ-037 Cancel with coin same cycle: credit 7, cancel=1 plus coin 2 -> refund_amount=7, coin_reject=1, credit=0, IDLE.
REQ-038 Controller busy: credit 10, wash_done=0 -> no coin_in; wash_done rises -> coin_in 1 cycle later; coin during RUNNING rejected.
REQ-039 Reset in RUNNING: rst_n low -> busy=0, double_wash=0, credit=0, no refund_valid.
